fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch program counter sequencer.
// A level-sensitive Start arms the sequencer (PC and retire count cleared) and
// its falling edge launches a run. While running, the PC steps, takes absolute
// branches through a 32-entry target LUT, or stops on Halt and raises Ack.
module fetch_sequencer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        BranchEn,
    input  logic [4:0]  TargSel,
    input  logic        Halt,
    input  logic        LutWrEn,
    input  logic [4:0]  LutWrAddr,
    input  logic [9:0]  LutWrData,
    output logic [9:0]  ProgCtr,
    output logic        PcValid,
    output logic        Ack,
    output logic [15:0] InstCt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [9:0]  r_progCtr;
    logic [9:0]  w_progCtrNext;
    logic [15:0] r_instCt;
    logic [15:0] w_instCtNext;
    logic [15:0] w_instCtInc;
    logic [9:0]  r_lut [32];
    logic [9:0]  w_lutRd;

    // The LUT read is combinational, so a branch in the same cycle as a write
    // to the same entry naturally sees the old contents.
    assign w_lutRd = r_lut[TargSel];

    // The retire counter sticks at all-ones instead of wrapping.
    assign w_instCtInc = (r_instCt == 16'hFFFF) ? r_instCt : (r_instCt + 16'd1);

    assign ProgCtr = r_progCtr;
    assign InstCt  = r_instCt;
    assign PcValid = (r_state == RUN);
    assign Ack     = (r_state == DONE);

    // Next-state, next-PC and next-count decode; Start beats Halt beats branch.
    always_comb begin
        w_stateNext   = r_state;
        w_progCtrNext = r_progCtr;
        w_instCtNext  = r_instCt;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_stateNext   = ARMED;
                    w_progCtrNext = 10'd0;
                    w_instCtNext  = 16'd0;
                end
            end
            ARMED: begin
                w_progCtrNext = 10'd0;
                w_instCtNext  = 16'd0;
                if (!Start) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                if (Start) begin
                    w_stateNext   = ARMED;
                    w_progCtrNext = 10'd0;
                    w_instCtNext  = 16'd0;
                end else if (Halt) begin
                    w_stateNext  = DONE;
                    w_instCtNext = w_instCtInc;
                end else if (BranchEn) begin
                    w_progCtrNext = w_lutRd;
                    w_instCtNext  = w_instCtInc;
                end else begin
                    w_progCtrNext = r_progCtr + 10'd1;
                    w_instCtNext  = w_instCtInc;
                end
            end
            DONE: begin
                if (Start) begin
                    w_stateNext   = ARMED;
                    w_progCtrNext = 10'd0;
                    w_instCtNext  = 16'd0;
                end
            end
            default: begin
                w_stateNext   = IDLE;
                w_progCtrNext = 10'd0;
                w_instCtNext  = 16'd0;
            end
        endcase
    end

    // State, PC and retire-count registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_progCtr <= 10'd0;
            r_instCt  <= 16'd0;
        end else begin
            r_state   <= w_stateNext;
            r_progCtr <= w_progCtrNext;
            r_instCt  <= w_instCtNext;
        end
    end

    // Branch-target LUT: cleared by reset, writable in any state otherwise.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                r_lut[i] <= 10'd0;
            end
        end else if (LutWrEn) begin
            r_lut[LutWrAddr] <= LutWrData;
        end
    end

endmodule
